// File: rtl/hdmi_tx_pkg.sv
// rtl/hdmi_tx_pkg.sv - shared state encoding and table constants for the ADV7513 config sequencer
package hdmi_tx_pkg;

   typedef enum logic [3:0] {
      S_PWRUP,
      S_START,
      S_BYTE,
      S_ACK,
      S_STOP,
      S_GAP,
      S_DONE,
      S_ERROR,
      S_IDLE
   } state_t;

   localparam int         NUM_REGS     = 16;
   localparam logic [6:0] DEV_ADDR_DEF = 7'h39;

endpackage

// File: rtl/adv7513_init_rom.sv
// rtl/adv7513_init_rom.sv - combinational ADV7513 init table, index -> {register, value}
module adv7513_init_rom
   import hdmi_tx_pkg::*;
(
   input  logic [5:0]  i_index,
   output logic [15:0] o_entry
);

   always_comb begin
      case (i_index)
         6'd0:    o_entry = 16'h4110;
         6'd1:    o_entry = 16'h9803;
         6'd2:    o_entry = 16'h9AE0;
         6'd3:    o_entry = 16'h9C30;
         6'd4:    o_entry = 16'h9D61;
         6'd5:    o_entry = 16'hA2A4;
         6'd6:    o_entry = 16'hA3A4;
         6'd7:    o_entry = 16'hE0D0;
         6'd8:    o_entry = 16'hF900;
         6'd9:    o_entry = 16'h1500;
         6'd10:   o_entry = 16'h1630;
         6'd11:   o_entry = 16'h1702;
         6'd12:   o_entry = 16'h1846;
         6'd13:   o_entry = 16'hAF04;
         6'd14:   o_entry = 16'h4080;
         6'd15:   o_entry = 16'hD6C0;
         default: o_entry = 16'h0000;
      endcase
   end

endmodule

// File: rtl/hdmi_tx_config.sv
// rtl/hdmi_tx_config.sv - ADV7513 power-up I2C write sequencer with done/error status
// Optional HPD_REINIT_EN: hot-plug rising edge reruns the table.
module hdmi_tx_config
   import hdmi_tx_pkg::*;
#(
   parameter int         CLK_HZ       = 50000000,
   parameter int         I2C_HZ       = 100000,
   parameter int         PWRUP_CYCLES = 10000000,
   parameter logic [6:0] DEV_ADDR     = DEV_ADDR_DEF,
   parameter int         MAX_RETRY    = 3
) (
   input  logic       clock_50,
   input  logic       reset,
   input  logic       start,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_in,
   input  logic       hpd,
   output logic       busy,
   output logic       done,
   output logic       ack_error,
   output logic [5:0] reg_index
);

   localparam int QDIV = CLK_HZ / (4 * I2C_HZ);
   localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam int PW   = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
   localparam int RW   = $clog2(MAX_RETRY + 1);

   state_t          r_state, w_state;
   logic [QW-1:0]   r_qcnt;
   logic [PW-1:0]   r_pwr, w_pwr;
   logic [1:0]      r_q, w_q;
   logic [2:0]      r_bit, w_bit;
   logic [1:0]      r_byte, w_byte;
   logic [7:0]      r_shift, w_shift;
   logic [RW-1:0]   r_retry, w_retry, w_retry_inc;
   logic [5:0]      r_idx, w_idx;
   logic            r_nack, w_nack;
   logic            r_scl, w_scl, r_sda, w_sda;
   logic            r_busy, r_done, r_err;
   logic            w_qtick, w_idle, w_rerun;
   logic [15:0]     w_entry;

   adv7513_init_rom u_rom (
      .i_index (r_idx),
      .o_entry (w_entry)
   );

   assign w_qtick     = (r_qcnt == QW'(QDIV - 1));
   assign w_idle      = (r_state == S_DONE) || (r_state == S_ERROR) || (r_state == S_IDLE);
   assign w_retry_inc = r_retry + 1'b1;

`ifdef HPD_REINIT_EN
   logic [2:0] r_hpd_s;
   logic       r_hpd_pend;
   logic       w_hpd_rise;

   assign w_hpd_rise = r_hpd_s[1] & ~r_hpd_s[2];
   assign w_rerun    = start | w_hpd_rise | r_hpd_pend;

   // A plug event mid-run is remembered so the transmitter is reprogrammed once it finishes.
   always_ff @(posedge clock_50 or negedge reset) begin
      if (!reset) begin
         r_hpd_s    <= 3'b000;
         r_hpd_pend <= 1'b0;
      end else begin
         r_hpd_s <= {r_hpd_s[1:0], hpd};
         if (w_idle)
            r_hpd_pend <= 1'b0;
         else if (w_hpd_rise)
            r_hpd_pend <= 1'b1;
      end
   end
`else
   logic w_unused_hpd;
   assign w_unused_hpd = hpd;
   assign w_rerun      = start;
`endif

   always_ff @(posedge clock_50 or negedge reset) begin
      if (!reset)
         r_qcnt <= '0;
      else if (w_qtick)
         r_qcnt <= '0;
      else
         r_qcnt <= r_qcnt + 1'b1;
   end

   always_ff @(posedge clock_50 or negedge reset) begin
      if (!reset) begin
         r_state <= S_PWRUP;
         r_pwr   <= '0;
         r_q     <= 2'd0;
         r_bit   <= 3'd0;
         r_byte  <= 2'd0;
         r_shift <= 8'h00;
         r_retry <= '0;
         r_idx   <= 6'd0;
         r_nack  <= 1'b0;
         r_scl   <= 1'b0;
         r_sda   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_pwr   <= w_pwr;
         r_q     <= w_q;
         r_bit   <= w_bit;
         r_byte  <= w_byte;
         r_shift <= w_shift;
         r_retry <= w_retry;
         r_idx   <= w_idx;
         r_nack  <= w_nack;
         r_scl   <= w_scl;
         r_sda   <= w_sda;
         r_busy  <= !((w_state == S_DONE) || (w_state == S_ERROR) || (w_state == S_IDLE));
         r_done  <= (w_state == S_DONE);
         r_err   <= (w_state == S_ERROR);
      end
   end

   // Bit timing: q0 drive SDA, q1 release SCL, q2 sample, q3 pull SCL low.
   always_comb begin
      w_state = r_state;
      w_pwr   = r_pwr;
      w_q     = r_q;
      w_bit   = r_bit;
      w_byte  = r_byte;
      w_shift = r_shift;
      w_retry = r_retry;
      w_idx   = r_idx;
      w_nack  = r_nack;
      w_scl   = r_scl;
      w_sda   = r_sda;
      case (r_state)
         S_PWRUP: begin
            if (r_pwr == PW'(PWRUP_CYCLES - 1)) begin
               w_state = S_START;
               w_idx   = 6'd0;
               w_q     = 2'd0;
            end else begin
               w_pwr = r_pwr + 1'b1;
            end
         end
         S_DONE, S_ERROR, S_IDLE: begin
            if (w_rerun) begin
               w_state = S_START;
               w_idx   = 6'd0;
               w_retry = '0;
               w_q     = 2'd0;
            end
         end
         default: begin
            if (w_qtick) begin
               w_q = r_q + 2'd1;
               case (r_state)
                  S_START: begin
                     case (r_q)
                        2'd0: begin w_scl = 1'b0; w_sda = 1'b0; end
                        2'd1: w_sda = 1'b1;
                        2'd3: begin
                           w_scl   = 1'b1;
                           w_shift = {DEV_ADDR, 1'b0};
                           w_bit   = 3'd0;
                           w_byte  = 2'd0;
                           w_nack  = 1'b0;
                           w_state = S_BYTE;
                        end
                        default: ;
                     endcase
                  end
                  S_BYTE: begin
                     case (r_q)
                        2'd0: w_sda = ~r_shift[7];
                        2'd1: w_scl = 1'b0;
                        2'd3: begin
                           w_scl   = 1'b1;
                           w_shift = {r_shift[6:0], 1'b0};
                           w_bit   = r_bit + 3'd1;
                           if (r_bit == 3'd7)
                              w_state = S_ACK;
                        end
                        default: ;
                     endcase
                  end
                  S_ACK: begin
                     case (r_q)
                        2'd0: w_sda = 1'b0;
                        2'd1: w_scl = 1'b0;
                        2'd2: w_nack = sda_in;
                        default: begin
                           w_scl = 1'b1;
                           if (r_nack || r_byte == 2'd2) begin
                              w_state = S_STOP;
                           end else begin
                              w_byte  = r_byte + 2'd1;
                              w_shift = (r_byte == 2'd0) ? w_entry[15:8] : w_entry[7:0];
                              w_state = S_BYTE;
                           end
                        end
                     endcase
                  end
                  S_STOP: begin
                     case (r_q)
                        2'd0: w_sda = 1'b1;
                        2'd1: w_scl = 1'b0;
                        2'd2: w_sda = 1'b0;
                        default: w_state = S_GAP;
                     endcase
                  end
                  S_GAP: begin
                     if (r_q == 2'd3) begin
                        if (r_nack) begin
                           if (w_retry_inc == RW'(MAX_RETRY)) begin
                              w_state = S_ERROR;
                           end else begin
                              w_retry = w_retry_inc;
                              w_state = S_START;
                           end
                        end else if (r_idx == 6'(NUM_REGS - 1)) begin
                           w_state = S_DONE;
                        end else begin
                           w_idx   = r_idx + 6'd1;
                           w_retry = '0;
                           w_state = S_START;
                        end
                     end
                  end
                  default: w_state = S_IDLE;
               endcase
            end
         end
      endcase
   end

   assign scl_oe    = r_scl;
   assign sda_oe    = r_sda;
   assign busy      = r_busy;
   assign done      = r_done;
   assign ack_error = r_err;
   assign reg_index = r_idx;

endmodule

// File: tb/tb_hdmi_tx_config.sv
// tb/tb_hdmi_tx_config.sv - directed self-checking bench with I2C slave model and bus monitor
`timescale 1ns/1ps
module tb_hdmi_tx_config;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       hpd = 1'b0;
   logic       scl_oe, sda_oe, sda_in, busy, done, ack_error;
   logic [5:0] reg_index;
   logic       slave_pull = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [15:0] exp_tab [16] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30,
                                 16'h9D61, 16'hA2A4, 16'hA3A4, 16'hE0D0,
                                 16'hF900, 16'h1500, 16'h1630, 16'h1702,
                                 16'h1846, 16'hAF04, 16'h4080, 16'hD6C0};

   assign sda_in = ~(sda_oe | slave_pull);

   always #5 clk = ~clk;

   hdmi_tx_config #(
      .CLK_HZ(400), .I2C_HZ(100), .PWRUP_CYCLES(20), .DEV_ADDR(7'h39), .MAX_RETRY(3)
   ) dut (
      .clock_50(clk), .reset(rst_n), .start(start), .scl_oe(scl_oe), .sda_oe(sda_oe),
      .sda_in(sda_in), .hpd(hpd), .busy(busy), .done(done), .ack_error(ack_error),
      .reg_index(reg_index)
   );

   // Bus monitor and slave model
   logic        p_scl = 1'b1, p_sda = 1'b1, scl_l, sda_l, last_ack = 1'b0;
   int          mbit = 0, mbyte = 0;
   logic [7:0]  msh = 8'h00, mreg = 8'h00, mval = 8'h00;
   logic [15:0] wlog [$];
   logic [7:0]  nack_reg = 8'hFF;
   int          nack_left = 0, tgt_attempts = 0, addr_bad = 0;

   always @(negedge clk) begin
      scl_l = ~scl_oe;
      sda_l = sda_in;
      if (!rst_n) begin
         mbit = 0; mbyte = 0; slave_pull = 1'b0;
      end else if (p_scl && scl_l && p_sda && !sda_l) begin
         mbit = 0; mbyte = 0;
      end else if (p_scl && scl_l && !p_sda && sda_l) begin
         if (mbyte == 3 && last_ack) wlog.push_back({mreg, mval});
         mbit = 0; mbyte = 0;
      end else if (!p_scl && scl_l) begin
         if (mbit < 8) begin
            msh = {msh[6:0], sda_l};
            mbit++;
         end else begin
            mbit = 0;
            last_ack = !sda_l;
            mbyte++;
         end
      end else if (p_scl && !scl_l) begin
         if (mbit == 8) begin
            case (mbyte)
               0: begin
                  slave_pull = (msh == 8'h72);
                  if (msh != 8'h72) addr_bad++;
               end
               1: begin mreg = msh; slave_pull = 1'b1; end
               2: begin
                  mval = msh;
                  if (mreg == nack_reg) tgt_attempts++;
                  if (mreg == nack_reg && nack_left > 0) begin
                     slave_pull = 1'b0;
                     nack_left--;
                  end else begin
                     slave_pull = 1'b1;
                  end
               end
               default: slave_pull = 1'b0;
            endcase
         end else begin
            slave_pull = 1'b0;
         end
      end
      p_scl = scl_l;
      p_sda = sda_l;
   end

   task automatic pulse_start;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!(done || ack_error) && cyc < budget);
   endtask

   task automatic test_reset;
      int first;
      rst_n = 1'b0;
      wlog.delete();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL rst_scl_oe got %b want 0", scl_oe); end
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe got %b want 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
      checks++; if (ack_error !== 1'b0) begin errors++; $display("FAIL rst_ack_error got %b want 0", ack_error); end
      checks++; if (reg_index !== 6'd0) begin errors++; $display("FAIL rst_reg_index got %0d want 0", reg_index); end
      @(negedge clk) rst_n = 1'b1;
      first = -1;
      for (int c = 1; c <= 40 && first < 0; c++) begin
         @(posedge clk); #1;
         if (sda_oe) first = c;
      end
      checks++; if (first < 20 || first > 28) begin errors++; $display("FAIL pwrup_start_delay got %0d want 20..28", first); end
      checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL start_scl_high got %b want 0", scl_oe); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pwrup_busy got %b want 1", busy); end
   endtask

   task automatic test_full_table;
      int cyc;
      wait_idle(6000, cyc);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done got %b want 1 after %0d", done, cyc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy got %b want 0", busy); end
      checks++; if (ack_error !== 1'b0) begin errors++; $display("FAIL full_ack_error got %b want 0", ack_error); end
      checks++; if (reg_index !== 6'd15) begin errors++; $display("FAIL full_reg_index got %0d want 15", reg_index); end
      checks++; if (wlog.size() != 16) begin errors++; $display("FAIL full_count got %0d want 16", wlog.size()); end
      for (int i = 0; i < 16 && i < wlog.size(); i++) begin
         checks++;
         if (wlog[i] !== exp_tab[i]) begin errors++; $display("FAIL full_entry%0d got %h want %h", i, wlog[i], exp_tab[i]); end
      end
      checks++; if (addr_bad != 0) begin errors++; $display("FAIL full_addr got %0d bad want 0", addr_bad); end
      checks++; if ({scl_oe, sda_oe} !== 2'b00) begin errors++; $display("FAIL full_bus got %b want 00", {scl_oe, sda_oe}); end
   endtask

   task automatic test_retry;
      int cyc;
      wlog.delete();
      nack_reg = 8'h9C; nack_left = 2; tgt_attempts = 0;
      pulse_start();
      wait_idle(6000, cyc);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL retry_done got %b want 1", done); end
      checks++; if (ack_error !== 1'b0) begin errors++; $display("FAIL retry_ack_error got %b want 0", ack_error); end
      checks++; if (tgt_attempts != 3) begin errors++; $display("FAIL retry_attempts got %0d want 3", tgt_attempts); end
      checks++; if (wlog.size() != 16) begin errors++; $display("FAIL retry_count got %0d want 16", wlog.size()); end
      checks++; if (wlog.size() > 3 && wlog[3] !== 16'h9C30) begin errors++; $display("FAIL retry_entry3 got %h want 9c30", wlog[3]); end
   endtask

   task automatic test_error;
      int cyc;
      wlog.delete();
      nack_reg = 8'hA2; nack_left = 1000; tgt_attempts = 0;
      pulse_start();
      wait_idle(6000, cyc);
      checks++; if (ack_error !== 1'b1) begin errors++; $display("FAIL err_ack_error got %b want 1", ack_error); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL err_done got %b want 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy got %b want 0", busy); end
      checks++; if (reg_index !== 6'd5) begin errors++; $display("FAIL err_reg_index got %0d want 5", reg_index); end
      checks++; if (wlog.size() != 5) begin errors++; $display("FAIL err_count got %0d want 5", wlog.size()); end
      checks++; if ({scl_oe, sda_oe} !== 2'b00) begin errors++; $display("FAIL err_bus got %b want 00", {scl_oe, sda_oe}); end
      repeat (200) @(posedge clk);
      #1;
      checks++; if (tgt_attempts != 3) begin errors++; $display("FAIL err_attempts got %0d want 3", tgt_attempts); end
      checks++; if (ack_error !== 1'b1 || reg_index !== 6'd5) begin errors++; $display("FAIL err_hold got %b/%0d want 1/5", ack_error, reg_index); end
      nack_left = 0; nack_reg = 8'hFF;
   endtask

   task automatic test_back_to_back;
      int cyc, first;
      wlog.delete();
      pulse_start();
      checks++; if (ack_error !== 1'b0) begin errors++; $display("FAIL b2b_err_clear got %b want 0", ack_error); end
      repeat (150) @(posedge clk);
      pulse_start();
      #1;
      checks++; if (busy !== 1'b1 || reg_index !== 6'd1) begin errors++; $display("FAIL b2b_ignore got busy=%b idx=%0d want 1/1", busy, reg_index); end
      wait_idle(6000, cyc);
      checks++; if (done !== 1'b1 || wlog.size() != 16) begin errors++; $display("FAIL b2b_run1 got done=%b n=%0d want 1/16", done, wlog.size()); end
      wlog.delete();
      pulse_start();
      #1;
      checks++; if (done !== 1'b0 || reg_index !== 6'd0) begin errors++; $display("FAIL b2b_restart got done=%b idx=%0d want 0/0", done, reg_index); end
      first = -1;
      for (int c = 1; c <= 40 && first < 0; c++) begin
         @(posedge clk); #1;
         if (sda_oe) first = c;
      end
      checks++; if (first < 1 || first > 4) begin errors++; $display("FAIL b2b_latency got %0d want 1..4", first); end
      wait_idle(6000, cyc);
      checks++; if (done !== 1'b1 || wlog.size() != 16) begin errors++; $display("FAIL b2b_run2 got done=%b n=%0d want 1/16", done, wlog.size()); end
   endtask

   task automatic test_reset_mid;
      int cyc;
      bit early;
      wlog.delete();
      pulse_start();
      cyc = 0;
      while (!(mbyte == 1 && mbit >= 3 && scl_oe) && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (cyc >= 400) begin errors++; $display("FAIL mid_reach got %0d cycles want <400", cyc); end
      rst_n = 1'b0;
      #1;
      checks++; if ({scl_oe, sda_oe} !== 2'b00) begin errors++; $display("FAIL mid_release got %b want 00", {scl_oe, sda_oe}); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
      @(negedge clk) rst_n = 1'b1;
      early = 1'b0;
      for (int c = 0; c < 19; c++) begin
         @(posedge clk); #1;
         if (sda_oe || scl_oe) early = 1'b1;
      end
      checks++; if (early) begin errors++; $display("FAIL mid_pwrup got activity=1 want 0"); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_pwrup_busy got %b want 1", busy); end
      wait_idle(6000, cyc);
      checks++; if (done !== 1'b1 || wlog.size() != 16) begin errors++; $display("FAIL mid_rerun got done=%b n=%0d want 1/16", done, wlog.size()); end
   endtask

   task automatic test_hpd;
      int cyc;
      bit seen;
`ifdef HPD_REINIT_EN
      @(negedge clk) hpd = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin @(posedge clk); #1; if (busy) seen = 1'b1; end
      checks++; if (!seen) begin errors++; $display("FAIL hpd_done_rerun got busy=0 want 1"); end
      repeat (100) @(posedge clk);
      @(negedge clk) hpd = 1'b0;
      repeat (5) @(negedge clk);
      hpd = 1'b1;
      wait_idle(6000, cyc);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL hpd_run1 got %b want 1", done); end
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin @(posedge clk); #1; if (busy) seen = 1'b1; end
      checks++; if (!seen) begin errors++; $display("FAIL hpd_pending got busy=0 want 1"); end
      wait_idle(6000, cyc);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL hpd_run2 got %b want 1", done); end
      repeat (300) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL hpd_single got busy=%b done=%b want 0/1", busy, done); end
`else
      @(negedge clk) hpd = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin @(posedge clk); #1; if (busy) seen = 1'b1; end
      checks++; if (seen || done !== 1'b1) begin errors++; $display("FAIL hpd_ignored got busy_seen=%b done=%b want 0/1", seen, done); end
      cyc = 0;
`endif
      hpd = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_table();
      test_retry();
      test_error();
      test_back_to_back();
      test_reset_mid();
      test_hpd();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

endmodule
